// File: rtl/aq_djpeg_idct_xpose_if.sv
// Bus between the IDCT row pass, the transpose buffer and the column pass.
// The row/column pass logic is the master; the transpose buffer is the slave.
interface aq_djpeg_idct_xpose_if #(
  parameter int DW = 16
);
  logic          DataInit;
  logic          DataInEnable;
  logic [2:0]    DataInPage;
  logic [1:0]    DataInCount;
  logic          DataInMode;
  logic [DW-1:0] DataInA;
  logic [DW-1:0] DataInB;
  logic          DataInIdle;
  logic          DataOutEnable;
  logic          DataOutRead;
  logic [4:0]    DataOutAddress;
  logic          DataOutValid;
  logic          DataOutMode;
  logic [DW-1:0] DataOutA;
  logic [DW-1:0] DataOutB;
  logic          ErrOverflow;
  logic          ErrUnderflow;

  modport master (
    output DataInit, DataInEnable, DataInPage, DataInCount, DataInMode,
           DataInA, DataInB, DataOutRead, DataOutAddress,
    input  DataInIdle, DataOutEnable, DataOutValid, DataOutMode,
           DataOutA, DataOutB, ErrOverflow, ErrUnderflow
  );

  modport slave (
    input  DataInit, DataInEnable, DataInPage, DataInCount, DataInMode,
           DataInA, DataInB, DataOutRead, DataOutAddress,
    output DataInIdle, DataOutEnable, DataOutValid, DataOutMode,
           DataOutA, DataOutB, ErrOverflow, ErrUnderflow
  );
endinterface

// File: rtl/aq_djpeg_idct_xpose.sv
// Transpose/reorder buffer between the IDCT row and column passes.
// 8x8 blocks arrive as butterfly pairs (row p, cols c and 7-c) into a ring of
// BANKS block buffers and leave either as column pairs (transpose mode) or as
// row pairs (row mode). Element (r, col) lives in memory r[2]^col[2] at word
// {bank, col, r[1:0]}, so every write pair and every read pair touches both
// memories exactly once.
module aq_djpeg_idct_xpose #(
  parameter int DW    = 16,
  parameter int BANKS = 4
) (
  input logic                  clk,
  input logic                  rst,
  aq_djpeg_idct_xpose_if.slave bus
);
  localparam int PW = $clog2(BANKS);
  localparam int FW = $clog2(BANKS + 1);
  localparam int AW = PW + 5;

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [FW-1:0]    fillCnt;
  logic [BANKS-1:0] modeBank;
  logic             validReg;
  logic             aFromMem1;
  logic             errOv;
  logic             errUn;

  logic [4:0]    wrAddr;
  logic          wrAcc;
  logic          rdAcc;
  logic          wrLast;
  logic          rdLast;
  logic [2:0]    colA;
  logic [2:0]    colB;
  logic [AW-1:0] wrWordA;
  logic [AW-1:0] wrWordB;
  logic [2:0]    rdQ;
  logic [1:0]    rdK;
  logic          rowMode;
  logic [AW-1:0] rdWordA;
  logic [AW-1:0] rdWordB;

  assign bus.DataInIdle    = (fillCnt != FW'(BANKS));
  assign bus.DataOutEnable = (fillCnt != '0);

  // DataInit wins over any transfer in the same cycle.
  assign wrAddr = {bus.DataInPage, bus.DataInCount};
  assign wrAcc  = bus.DataInEnable && bus.DataInIdle && !bus.DataInit;
  assign rdAcc  = bus.DataOutRead && bus.DataOutEnable && !bus.DataInit;
  assign wrLast = wrAcc && (wrAddr == 5'd31);
  assign rdLast = rdAcc && (bus.DataOutAddress == 5'd31);

  // Write pair: A is (p, c) with c < 4, so it sits in memory p[2];
  // B is (p, 7-c) and always lands in the other memory.
  assign colA    = {1'b0, bus.DataInCount};
  assign colB    = 3'd7 - colA;
  assign wrWordA = {wrPtr, colA, bus.DataInPage[1:0]};
  assign wrWordB = {wrPtr, colB, bus.DataInPage[1:0]};

  // Read pair: in both modes A lives in memory q[2] and B in the other one.
  // Transpose: A=(k,q), B=(7-k,q).  Row: A=(q,k), B=(q,7-k).
  assign rdQ     = bus.DataOutAddress[4:2];
  assign rdK     = bus.DataOutAddress[1:0];
  assign rowMode = modeBank[rdPtr];

  // Word addresses of the two read elements for the current mode.
  always_comb begin
    rdWordA = {rdPtr, rdQ, rdK};
    rdWordB = {rdPtr, rdQ, ~rdK};
    if (rowMode) begin
      rdWordA = {rdPtr, 1'b0, rdK, rdQ[1:0]};
      rdWordB = {rdPtr, 3'd7 - {1'b0, rdK}, rdQ[1:0]};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gMem
      logic [DW-1:0] mem [BANKS*32];
      logic [AW-1:0] wAddr;
      logic [DW-1:0] wData;
      logic [AW-1:0] rAddr;
      logic [DW-1:0] rdWord;

      assign wAddr = (bus.DataInPage[2] == 1'(gi)) ? wrWordA : wrWordB;
      assign wData = (bus.DataInPage[2] == 1'(gi)) ? bus.DataInA : bus.DataInB;
      assign rAddr = (rdQ[2] == 1'(gi)) ? rdWordA : rdWordB;

      // Block storage write port; contents survive reset and DataInit.
      always_ff @(posedge clk) begin
        if (wrAcc) mem[wAddr] <= wData;
      end

      // Registered read port, held until the next accepted read.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rdWord <= '0;
        else if (rdAcc) rdWord <= mem[rAddr];
      end
    end
  endgenerate

  // Remember which memory returned the A sample of the last accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       aFromMem1 <= 1'b0;
    else if (rdAcc) aFromMem1 <= rdQ[2];
  end

  // Per-bank mode, captured with the first pair of each block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          modeBank <= '0;
    else if (wrAcc && wrAddr == 5'd0)  modeBank[wrPtr] <= bus.DataInMode;
  end

  // Ring pointers, occupancy, read-valid strobe and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      fillCnt  <= '0;
      validReg <= 1'b0;
      errOv    <= 1'b0;
      errUn    <= 1'b0;
    end else if (bus.DataInit) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      fillCnt  <= '0;
      validReg <= 1'b0;
      errOv    <= 1'b0;
      errUn    <= 1'b0;
    end else begin
      if (wrLast) wrPtr <= wrPtr + PW'(1);
      if (rdLast) rdPtr <= rdPtr + PW'(1);
      if (wrLast && !rdLast)      fillCnt <= fillCnt + FW'(1);
      else if (rdLast && !wrLast) fillCnt <= fillCnt - FW'(1);
      validReg <= rdAcc;
      if (bus.DataInEnable && !bus.DataInIdle)   errOv <= 1'b1;
      if (bus.DataOutRead && !bus.DataOutEnable) errUn <= 1'b1;
    end
  end

  assign bus.DataOutValid = validReg;
  assign bus.DataOutMode  = rowMode;
  assign bus.DataOutA     = aFromMem1 ? gMem[1].rdWord : gMem[0].rdWord;
  assign bus.DataOutB     = aFromMem1 ? gMem[0].rdWord : gMem[1].rdWord;
  assign bus.ErrOverflow  = errOv;
  assign bus.ErrUnderflow = errUn;
endmodule
